bayer_mosaic: RTL and testbench

Re-mosaics a raster RGB pixel stream into a single-channel 8-bit Bayer raw stream. It is the inverse of the demosaic stage: it feeds synthetic or processed RGB frames back into the raw-domain pipeline and the demosaic bench. Position counters select one colour per pixel according to the CFA pattern. A 2-entry output buffer provides valid/ready backpressure toward the raw consumer.

---
 rtl/bayer_pkg.sv | 43 ++++
 rtl/bayer_skid_fifo.sv | 57 +++++
 rtl/bayer_mosaic.sv | 118 +++++++++++
 tb/tb_bayer_mosaic.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_pkg.sv
// Shared Bayer CFA definitions: pattern phase codes, colour channel enum and
// the per-site channel lookup used by the mosaic and demosaic stages.
package bayer_pkg;

   localparam logic [1:0] PAT_RGGB = 2'd0;
   localparam logic [1:0] PAT_GRBG = 2'd1;
   localparam logic [1:0] PAT_GBRG = 2'd2;
   localparam logic [1:0] PAT_BGGR = 2'd3;

   typedef enum logic [1:0] {
      CH_R = 2'd0,
      CH_G = 2'd1,
      CH_B = 2'd2
   } channel_t;

   // Colour sampled at a CFA site, given the phase at (0,0) and the row/column parity.
   function automatic channel_t channel_sel(input logic [1:0] pattern,
                                            input logic y0,
                                            input logic x0);
      channel_t ch;
      ch = CH_G;
      case (pattern)
         PAT_RGGB: begin
            if ({y0, x0} == 2'b00)      ch = CH_R;
            else if ({y0, x0} == 2'b11) ch = CH_B;
         end
         PAT_GRBG: begin
            if ({y0, x0} == 2'b01)      ch = CH_R;
            else if ({y0, x0} == 2'b10) ch = CH_B;
         end
         PAT_GBRG: begin
            if ({y0, x0} == 2'b01)      ch = CH_B;
            else if ({y0, x0} == 2'b10) ch = CH_R;
         end
         default: begin
            if ({y0, x0} == 2'b00)      ch = CH_B;
            else if ({y0, x0} == 2'b11) ch = CH_R;
         end
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/bayer_skid_fifo.sv
// Two-entry valid/ready FIFO; in_ready depends only on the registered count,
// so there is no combinational path from out_ready back to the producer.
module bayer_skid_fifo #(
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   logic [DW-1:0] mem_reg [2];
   logic [1:0]    count_reg;
   logic          wr_ptr_reg;
   logic          rd_ptr_reg;
   logic          push;
   logic          pop;

   assign in_ready  = (count_reg != 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_ready & out_valid;
   assign out_data  = mem_reg[rd_ptr_reg];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (reset) begin
               mem_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
               mem_reg[gi] <= in_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/bayer_mosaic.sv
// RGB raster to 8-bit Bayer raw re-mosaic with a 2-entry output buffer.
// Define BAYER_MOSAIC_PATTERN_PORT_EN to add a per-frame runtime iPattern input.
module bayer_mosaic
   import bayer_pkg::*;
#(
   parameter int WIDTH         = 320,
   parameter int HEIGHT        = 240,
   parameter int BAYER_PATTERN = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] iR,
   input  logic [7:0] iG,
   input  logic [7:0] iB,
   input  logic       iValid,
   output logic       iReady,
`ifdef BAYER_MOSAIC_PATTERN_PORT_EN
   input  logic [1:0] iPattern,
`endif
   output logic [7:0] oData,
   output logic       oValid,
   input  logic       oReady,
   output logic       oLast,
   output logic       oDone
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   logic [XW-1:0] x_reg;
   logic [YW-1:0] y_reg;
   logic          x_last;
   logic          y_last;
   logic          accept;
   logic          fifo_ready;
   logic          out_valid;
   logic [8:0]    head;
   logic [1:0]    pattern_cur;
   channel_t      channel;
   logic [7:0]    pixel_sel;
   logic          done_reg;

   assign x_last = (x_reg == XW'(WIDTH - 1));
   assign y_last = (y_reg == YW'(HEIGHT - 1));
   assign accept = iValid & fifo_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         x_reg <= '0;
         y_reg <= '0;
      end else if (accept) begin
         if (x_last) begin
            x_reg <= '0;
            y_reg <= y_last ? '0 : y_reg + YW'(1);
         end else begin
            x_reg <= x_reg + XW'(1);
         end
      end
   end

`ifdef BAYER_MOSAIC_PATTERN_PORT_EN
   logic [1:0] pattern_reg;
   logic       frame_start;

   // Pixel (0,0) already uses the incoming pattern; the rest of the frame uses the latched copy.
   assign frame_start = (x_reg == '0) && (y_reg == '0);
   assign pattern_cur = frame_start ? iPattern : pattern_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_reg <= 2'(BAYER_PATTERN);
      end else if (accept && frame_start) begin
         pattern_reg <= iPattern;
      end
   end
`else
   assign pattern_cur = 2'(BAYER_PATTERN);
`endif

   assign channel = channel_sel(pattern_cur, y_reg[0], x_reg[0]);

   always_comb begin
      pixel_sel = iG;
      case (channel)
         CH_R:    pixel_sel = iR;
         CH_B:    pixel_sel = iB;
         default: pixel_sel = iG;
      endcase
   end

   bayer_skid_fifo #(
      .DW (9)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({x_last & y_last, pixel_sel}),
      .in_valid  (iValid),
      .in_ready  (fifo_ready),
      .out_data  (head),
      .out_valid (out_valid),
      .out_ready (oReady)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         done_reg <= 1'b0;
      end else begin
         done_reg <= out_valid & oReady & head[8];
      end
   end

   assign iReady = fifo_ready;
   assign oValid = out_valid;
   assign oData  = head[7:0];
   assign oLast  = head[8];
   assign oDone  = done_reg;

endmodule

// File: tb/tb_bayer_mosaic.sv
// Scoreboard bench for bayer_mosaic: two instances (RGGB and BGGR) share stimulus;
// a CFA-string reference model predicts each accepted pixel.
module tb_bayer_mosaic;

   localparam int W = 4;
   localparam int H = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] iR, iG, iB;
   logic       iValid;
   logic       oReady;
   logic [1:0] pattern_in;

   logic       ready_a, valid_a, last_a, done_a;
   logic [7:0] data_a;
   logic       ready_b, valid_b, last_b, done_b;
   logic [7:0] data_b;

   always #5 clk = ~clk;

   bayer_mosaic #(.WIDTH(W), .HEIGHT(H), .BAYER_PATTERN(0)) dut (
      .clk      (clk),
      .reset    (reset),
      .iR       (iR),
      .iG       (iG),
      .iB       (iB),
      .iValid   (iValid),
      .iReady   (ready_a),
`ifdef BAYER_MOSAIC_PATTERN_PORT_EN
      .iPattern (pattern_in),
`endif
      .oData    (data_a),
      .oValid   (valid_a),
      .oReady   (oReady),
      .oLast    (last_a),
      .oDone    (done_a)
   );

   bayer_mosaic #(.WIDTH(W), .HEIGHT(H), .BAYER_PATTERN(3)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .iR       (iR),
      .iG       (iG),
      .iB       (iB),
      .iValid   (iValid),
      .iReady   (ready_b),
`ifdef BAYER_MOSAIC_PATTERN_PORT_EN
      .iPattern (2'd3),
`endif
      .oData    (data_b),
      .oValid   (valid_b),
      .oReady   (oReady),
      .oLast    (last_b),
      .oDone    (done_b)
   );

   typedef struct {
      logic [7:0] exp_a;
      logic [7:0] exp_b;
      logic       last;
   } entry_t;

   entry_t     sb[$];
   logic [7:0] log_a[$];
   logic [7:0] log_b[$];
   int         done_cyc[$];
   string      cfa[4] = '{"RGGB", "GRBG", "GBRG", "BGGR"};
   int         checks = 0;
   int         errors = 0;
   int         mx = 0, my = 0, pix_k = 0, cyc = 0;
   int         pat_model = 0;
   logic       done_exp = 1'b0;
   logic       rand_data = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: look up the CFA letter for the site's parity and take that colour.
   function automatic logic [7:0] pick(input int pat, input int x, input int y,
                                       input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
      string s;
      byte   c;
      s = cfa[pat];
      c = s[2 * (y % 2) + (x % 2)];
      if (c == "R") return r;
      if (c == "B") return b;
      return g;
   endfunction

   // Monitor and input-side model in one process so checks precede new pushes.
   always @(negedge clk) begin
      int   size_before;
      logic done_next;
      entry_t e;
      cyc++;
      if (reset) begin
         sb.delete();
         mx = 0; my = 0; pix_k = 0;
         pat_model = 0;
         done_exp = 1'b0;
      end else begin
         if (done_a) done_cyc.push_back(cyc);
         check("done_a", done_a, done_exp);
         check("done_b", done_b, done_exp);
         size_before = sb.size();
         check("ready_a", ready_a, size_before < 2);
         check("ready_b", ready_b, size_before < 2);
         check("valid_a", valid_a, size_before > 0);
         check("valid_b", valid_b, size_before > 0);
         done_next = 1'b0;
         if (size_before > 0) begin
            check("data_a", data_a, sb[0].exp_a);
            check("last_a", last_a, sb[0].last);
            check("data_b", data_b, sb[0].exp_b);
            check("last_b", last_b, sb[0].last);
            if (oReady) begin
               done_next = sb[0].last;
               log_a.push_back(data_a);
               log_b.push_back(data_b);
               void'(sb.pop_front());
            end
         end
         done_exp = done_next;
         if (iValid && size_before < 2) begin
`ifdef BAYER_MOSAIC_PATTERN_PORT_EN
            if (mx == 0 && my == 0) pat_model = int'(pattern_in);
`endif
            e.exp_a = pick(pat_model, mx, my, iR, iG, iB);
            e.exp_b = pick(3, mx, my, iR, iG, iB);
            e.last  = (mx == W - 1) && (my == H - 1);
            sb.push_back(e);
            pix_k++;
            if (mx == W - 1) begin
               mx = 0;
               my = (my == H - 1) ? 0 : my + 1;
            end else begin
               mx++;
            end
         end
      end
   end

   task automatic drive(input logic v, input logic r);
      iValid = v;
      oReady = r;
      if (rand_data) begin
         iR = 8'($urandom);
         iG = 8'($urandom);
         iB = 8'($urandom);
      end else begin
         iR = 8'(pix_k);
         iG = 8'(16 + pix_k);
         iB = 8'(32 + pix_k);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      drive(1'b0, 1'b1);
      @(posedge clk); #1;
      check("rst_valid", valid_a, 1'b0);
      check("rst_data", data_a, 8'd0);
      check("rst_last", last_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_ready", ready_a, 1'b1);
      reset = 1'b0;
      log_a.delete();
      log_b.delete();
      done_cyc.delete();
   endtask

   task automatic check_frame(input string name, input int base, input logic [7:0] ga[8],
                              input logic [7:0] gb[8]);
      check({name, "_count"}, (log_a.size() >= base + 8), 1'b1);
      if (log_a.size() >= base + 8) begin
         for (int i = 0; i < 8; i++) begin
            check({name, "_a"}, log_a[base + i], ga[i]);
            check({name, "_b"}, log_b[base + i], gb[i]);
         end
      end
   endtask

   logic [7:0] gold_rggb1[8] = '{8'd0, 8'd17, 8'd2, 8'd19, 8'd20, 8'd37, 8'd22, 8'd39};
   logic [7:0] gold_bggr1[8] = '{8'd32, 8'd17, 8'd34, 8'd19, 8'd20, 8'd5, 8'd22, 8'd7};
   logic [7:0] gold_rggb2[8] = '{8'd8, 8'd25, 8'd10, 8'd27, 8'd28, 8'd45, 8'd30, 8'd47};
   logic [7:0] gold_bggr2[8] = '{8'd40, 8'd25, 8'd42, 8'd27, 8'd28, 8'd13, 8'd30, 8'd15};

   initial begin
      reset      = 1'b1;
      pattern_in = 2'd0;
      drive(1'b0, 1'b1);
      repeat (2) @(posedge clk);
      do_reset();

      // Two back-to-back frames, no gaps; pattern input changes mid-frame 1.
      for (int i = 0; i < 24; i++) begin
         if (pix_k >= 4) pattern_in = 2'd3;
         drive(pix_k < 16, 1'b1);
         @(posedge clk); #1;
      end
      check_frame("frame1", 0, gold_rggb1, gold_bggr1);
`ifdef BAYER_MOSAIC_PATTERN_PORT_EN
      check_frame("frame2", 8, gold_bggr2, gold_bggr2);
`else
      check_frame("frame2", 8, gold_rggb2, gold_bggr2);
`endif
      check("done_pulses", done_cyc.size(), 2);
      if (done_cyc.size() == 2) check("done_spacing", done_cyc[1] - done_cyc[0], 8);

      // Backpressure: stall the consumer with the producer always valid.
      pattern_in = 2'd0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0);
         @(posedge clk); #1;
      end
      check("bp_accepted", pix_k, 2);
      check("bp_ready", ready_a, 1'b0);
      check("bp_hold", data_a, 8'd0);
      for (int i = 0; i < 30; i++) begin
         drive(pix_k < 8, 1'b1);
         @(posedge clk); #1;
      end
      check_frame("bp", 0, gold_rggb1, gold_bggr1);
      check("bp_len", log_a.size(), 8);

      // Reset after three accepts discards the partial frame.
      do_reset();
      for (int i = 0; i < 20 && pix_k < 3; i++) begin
         drive(1'b1, 1'b1);
         @(posedge clk); #1;
      end
      check("mid_accepts", pix_k, 3);
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(pix_k < 8, 1'b1);
         @(posedge clk); #1;
      end
      check_frame("after_rst", 0, gold_rggb1, gold_bggr1);

      // Randomized traffic, data and pattern.
      rand_data = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         pattern_in = 2'($urandom);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
         if (i == 1500) reset = 1'b1;
         if (i == 1501) reset = 1'b0;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1);
         @(posedge clk); #1;
      end
      check("drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
